// File: rtl/sprite_plot_scheduler.sv
// Two-requester 4x4 sprite redraw scheduler for a vga_adapter: erases the old
// sprite position (if any), draws the new one, then pulses done for that requester.
module sprite_plot_scheduler #(
    parameter int X_MAX = 156,
    parameter int Y_MAX = 116
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [7:0] x0,
    input  logic [7:0] x1,
    input  logic [6:0] y0,
    input  logic [6:0] y1,
    input  logic [2:0] colour0,
    input  logic [2:0] colour1,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       plot,
    output logic       busy,
    output logic [1:0] done
);

    localparam logic [7:0] X_LIM = X_MAX[7:0];
    localparam logic [6:0] Y_LIM = Y_MAX[6:0];

    typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic            rr_ptr;
    logic            gnt;
    logic [7:0]      new_x;
    logic [6:0]      new_y;
    logic [2:0]      new_colour;
    logic [1:0]      old_valid;
    logic [1:0][7:0] old_x;
    logic [1:0][6:0] old_y;

    logic       pick;
    logic [7:0] sel_x;
    logic [6:0] sel_y;
    logic [2:0] sel_colour;

    // rr_ptr names the requester preferred on a tie: always the one not served last.
    always_comb begin
        pick = 1'b0;
        if (req == 2'b11)
            pick = rr_ptr;
        else
            pick = req[1];
        sel_x      = pick ? x1 : x0;
        sel_y      = pick ? y1 : y0;
        sel_colour = pick ? colour1 : colour0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            rr_ptr     <= 1'b0;
            gnt        <= 1'b0;
            new_x      <= 8'd0;
            new_y      <= 7'd0;
            new_colour <= 3'd0;
            old_valid  <= 2'b00;
            old_x      <= '0;
            old_y      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        gnt        <= pick;
                        new_x      <= (sel_x > X_LIM) ? X_LIM : sel_x;
                        new_y      <= (sel_y > Y_LIM) ? Y_LIM : sel_y;
                        new_colour <= sel_colour;
                        cnt        <= 4'd0;
                        state      <= old_valid[pick] ? ERASE : DRAW;
                    end
                end
                ERASE: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15)
                        state <= DRAW;
                end
                DRAW: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15)
                        state <= DONE;
                end
                DONE: begin
                    old_x[gnt]     <= new_x;
                    old_y[gnt]     <= new_y;
                    old_valid[gnt] <= 1'b1;
                    rr_ptr         <= ~gnt;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pixel outputs depend only on registered state, so reset clears them at once.
    always_comb begin
        x_out      = 8'd0;
        y_out      = 7'd0;
        colour_out = 3'd0;
        plot       = 1'b0;
        case (state)
            ERASE: begin
                plot  = 1'b1;
                x_out = old_x[gnt] + {6'd0, cnt[1:0]};
                y_out = old_y[gnt] + {5'd0, cnt[3:2]};
            end
            DRAW: begin
                plot       = 1'b1;
                x_out      = new_x + {6'd0, cnt[1:0]};
                y_out      = new_y + {5'd0, cnt[3:2]};
                colour_out = new_colour;
            end
            default: ;
        endcase
        busy = (state != IDLE);
        done = (state == DONE) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    end

endmodule

// File: tb/tb_sprite_plot_scheduler.sv
// Directed bench for sprite_plot_scheduler: table of redraw transactions with
// per-pixel checks, plus hand-written round-robin, drop-before-grant and reset-abort sequences.
module tb_sprite_plot_scheduler;

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic [7:0] x0, x1;
    logic [6:0] y0, y1;
    logic [2:0] colour0, colour1;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot;
    logic       busy;
    logic [1:0] done;

    int checks = 0;
    int errors = 0;

    sprite_plot_scheduler #(.X_MAX(156), .Y_MAX(116)) dut (
        .clk(clk), .reset(reset), .req(req),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1),
        .colour0(colour0), .colour1(colour1),
        .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
        .plot(plot), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0] req;
        logic [7:0] x0, x1;
        logic [6:0] y0, y1;
        logic [2:0] c0, c1;
        int         g;
        bit         erase;
        int         ox, oy, nx, ny;
        logic [2:0] col;
    } vec_t;

    vec_t vecs[3];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // {done, plot, busy, x_out, y_out, colour_out}
    function automatic logic [31:0] snap();
        return {10'd0, done, plot, busy, x_out, y_out, colour_out};
    endfunction

    function automatic logic [31:0] pix(input int bx, input int by, input int j, input logic [2:0] c);
        logic [7:0] ex;
        logic [6:0] ey;
        ex = 8'(bx + j % 4);
        ey = 7'(by + j / 4);
        return {10'd0, 2'b00, 1'b1, 1'b1, ex, ey, c};
    endfunction

    task automatic apply_stimulus(input vec_t v);
        x0 = v.x0; y0 = v.y0; colour0 = v.c0;
        x1 = v.x1; y1 = v.y1; colour1 = v.c1;
        req = v.req;
    endtask

    // Starts in an IDLE cycle with inputs set; returns at the DONE-cycle negedge.
    task automatic run_redraw(input int g, input bit erase, input int ox, input int oy,
                              input int nx, input int ny, input logic [2:0] col, input bit scramble);
        int n;
        bit ep;
        n = erase ? 32 : 16;
        @(posedge clk);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            ep = erase && (k < 16);
            check_output($sformatf("pixel_g%0d_k%0d", g, k), snap(),
                         ep ? pix(ox, oy, k % 16, 3'b000) : pix(nx, ny, k % 16, col));
            if (scramble && k == 0) begin
                x0 = 8'h55; x1 = 8'h55; y0 = 7'h2A; y1 = 7'h2A;
                colour0 = 3'b010; colour1 = 3'b010; req = 2'b00;
            end
        end
        @(negedge clk);
        check_output($sformatf("done_g%0d", g), snap(),
                     {10'd0, 2'(1 << g), 1'b0, 1'b1, 8'd0, 7'd0, 3'd0});
    endtask

    initial begin
        vecs[0] = '{req: 2'b01, x0: 8'd10, y0: 7'd20, c0: 3'b100, x1: 8'd0, y1: 7'd0, c1: 3'b000,
                    g: 0, erase: 1'b0, ox: 0, oy: 0, nx: 10, ny: 20, col: 3'b100};
        vecs[1] = '{req: 2'b01, x0: 8'd11, y0: 7'd20, c0: 3'b100, x1: 8'd0, y1: 7'd0, c1: 3'b000,
                    g: 0, erase: 1'b1, ox: 10, oy: 20, nx: 11, ny: 20, col: 3'b100};
        vecs[2] = '{req: 2'b10, x0: 8'd11, y0: 7'd20, c0: 3'b100, x1: 8'd200, y1: 7'd127, c1: 3'b011,
                    g: 1, erase: 1'b0, ox: 0, oy: 0, nx: 156, ny: 116, col: 3'b011};

        reset = 1'b1; req = 2'b00;
        x0 = 8'd0; x1 = 8'd0; y0 = 7'd0; y1 = 7'd0; colour0 = 3'd0; colour1 = 3'd0;
        #1;
        check_output("reset_state", snap(), 32'd0);
        @(negedge clk);
        check_output("reset_held", snap(), 32'd0);
        reset = 1'b0;

        // Table: first draw, erase+draw, clamped draw; inputs scrambled while busy.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(vecs[i]);
            run_redraw(vecs[i].g, vecs[i].erase, vecs[i].ox, vecs[i].oy,
                       vecs[i].nx, vecs[i].ny, vecs[i].col, 1'b1);
            req = 2'b00;
            @(negedge clk);
            check_output($sformatf("idle_after_vec%0d", i), snap(), 32'd0);
        end

        // Both requesting: requester 1 was served last, so grants run 0,1,0,1.
        x0 = 8'd11; y0 = 7'd20; colour0 = 3'b100;
        x1 = 8'd200; y1 = 7'd127; colour1 = 3'b011;
        req = 2'b11;
        for (int r = 0; r < 4; r++) begin
            if (r % 2 == 0)
                run_redraw(0, 1'b1, 11, 20, 11, 20, 3'b100, 1'b0);
            else
                run_redraw(1, 1'b1, 156, 116, 156, 116, 3'b011, 1'b0);
            @(negedge clk);
            check_output($sformatf("rr_gap%0d", r), {30'd0, busy, plot}, 32'd0);
            if (r == 3) req = 2'b00;
        end

        // Request withdrawn before any clock edge sees it.
        req = 2'b01;
        #2 req = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_output($sformatf("dropped_req%0d", k), snap(), 32'd0);
        end

        // Reset during the fifth DRAW cycle aborts with no done pulse.
        x0 = 8'd30; y0 = 7'd40; colour0 = 3'b111; req = 2'b01;
        @(posedge clk);
        for (int k = 0; k < 21; k++) @(negedge clk);
        check_output("draw_cycle5", snap(), pix(30, 40, 4, 3'b111));
        #2 reset = 1'b1;
        #1 check_output("reset_abort", snap(), 32'd0);
        @(negedge clk);
        check_output("reset_abort_held", snap(), 32'd0);
        reset = 1'b0;
        run_redraw(0, 1'b0, 0, 0, 30, 40, 3'b111, 1'b0);
        req = 2'b00;
        @(negedge clk);
        check_output("idle_final", snap(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_plot_scheduler.md
SPRITE_PLOT_SCHEDULER -- requirements
Module: sprite_plot_scheduler

Interface
REQ-001 Parameter X_MAX, 156, largest legal sprite origin x; a 4x4 sprite then ends at x=159.
REQ-002 Parameter Y_MAX, 116, largest legal sprite origin y; a 4x4 sprite then ends at y=119.
REQ-003 The module SHALL have these ports:
- clk  in  1  sole clock; rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  2  per-requester redraw request; level; held until matching done.
- x0, x1  in  8 each  new sprite origin x, requester 0 and 1.
- y0, y1  in  7 each  new sprite origin y, requester 0 and 1.
- colour0, colour1  in  3 each  sprite colour, requester 0 and 1.
- x_out  out  8  pixel x to the vga_adapter.
- y_out  out  7  pixel y to the vga_adapter.
- colour_out  out  3  pixel colour to the vga_adapter.
- plot  out  1  pixel write enable to the vga_adapter.
- busy  out  1  high in any state other than IDLE.
- done  out  2  one-cycle pulse per requester when its redraw completes.

Function
REQ-004 The FSM SHALL have states IDLE, ERASE, DRAW and DONE.
REQ-005 In IDLE with req nonzero, the clock edge SHALL perform all of the following:
- grant one requester;
- latch that requester's x, y and colour;
- go to ERASE if that requester's old_valid=1, else go to DRAW;
- clear the 4-bit pixel counter to 0.
REQ-006 Arbitration SHALL be round-robin: when both req bits are high, grant the requester not served last; pointer resets to requester 0.
REQ-007 Latched x greater than X_MAX SHALL be clamped to X_MAX; latched y greater than Y_MAX SHALL be clamped to Y_MAX.
REQ-008 In ERASE and in DRAW, outputs SHALL be as follows, and the counter SHALL increment once per cycle:
- plot=1;
- x_out = base_x + cnt[1:0];
- y_out = base_y + cnt[3:2].
REQ-009 ERASE SHALL use the granted requester's stored old position with colour_out=000, and on cnt=15 SHALL go to DRAW with cnt cleared.
REQ-010 DRAW SHALL use the latched new position and colour, and on cnt=15 SHALL go to DONE.
REQ-011 DONE SHALL last exactly one cycle, with these actions:
- pulse done[granted];
- plot=0;
- copy the latched position into that requester's old-position store and set its old_valid;
- toggle the round-robin pointer;
- return to IDLE.
REQ-012 Latency SHALL be fixed:
- request edge to first plot: 1 cycle;
- erase + draw: 32 plot cycles;
- first draw (old_valid=0): 16 plot cycles;
- done asserted 33 (or 17) cycles after the grant edge.
REQ-013 Changes on req, x*, y* or colour* while busy SHALL be ignored; no pre-emption occurs.
REQ-014 A requester whose req drops before grant SHALL not be served.
REQ-015 A req still high in the DONE cycle SHALL be eligible at the next IDLE edge, giving a one-cycle IDLE gap.
REQ-016 Outside ERASE and DRAW, outputs SHALL be plot=0, x_out=0, y_out=0, colour_out=0.
REQ-017 x_out, y_out, colour_out and plot SHALL be decoded from registered state/counter only, with no combinational path from req or x*/y* inputs.

Reset
REQ-018 reset SHALL immediately, without waiting for clk, drive all of the following:
- state to IDLE, counter to 0 and round-robin pointer to requester 0;
- old_valid[1:0] to 0 and old positions to 0;
- all outputs to 0.
REQ-019 Reset asserted mid-ERASE or mid-DRAW SHALL abort the operation with no done pulse; the next redraw after release skips ERASE.

Verification
REQ-020 After reset, req=01, x0=10, y0=20, colour0=100 -> plot high 16 cycles covering (10..13, 20..23) in raster order from (10,20), colour 100; done=01 on cycle 17.
REQ-021 Then x0=11, req=01 -> 16 pixels of colour 000 over (10..13, 20..23), then 16 pixels of colour 100 over (11..14, 20..23); done=01 on cycle 33.
REQ-022 req=11 held continuously after both requesters are drawn once -> grants alternate 0,1,0,1 starting with the requester not served last; each done pulse is followed by a one-cycle IDLE gap.
REQ-023 x1=200, y1=127, req=10 -> pixels cover x 156..159 and y 116..119; no pixel has x>159 or y>119.
REQ-024 Reset asserted at DRAW cycle 5 -> plot=0 and busy=0 immediately, no done pulse; the next req for that requester draws with no ERASE phase.
